// File: rtl/nt_serial_collector.sv
// Serial-to-parallel frame collector: gathers a preset number of serial bits
// (length loaded at frame start) and publishes the assembled word with a valid pulse.
module nt_serial_collector #(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 3,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             cnt,
  input  logic             ld_cnt,
  input  logic [CNT_W-1:0] init,
  output logic [WIDTH-1:0] parout,
  output logic             valid,
  output logic             busy,
  output logic             err
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // The longest frame (2**CNT_W bits) must fit in the output word.
  generate
    if ((CNT_W < 1) || ((2 ** CNT_W) > WIDTH)) begin : g_bad_params
      $error("nt_serial_collector: 2**CNT_W must be <= WIDTH and CNT_W >= 1");
    end
  endgenerate

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_rem;
  logic [CNT_W-1:0]   r_pos;
  logic [WIDTH-1:0]   r_sr;
  logic [WIDTH-1:0]   r_parout;
  logic               r_valid;
  logic               r_err;

  logic               w_load;
  logic               w_abort;
  logic               w_shift;
  logic               w_last;
  logic [IDX_W-1:0]   w_idx;
  logic [WIDTH-1:0]   w_sr_nxt;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_abort     = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (ld_cnt) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (ld_cnt) begin
          w_load  = 1'b1;
          w_abort = 1'b1;
        end else if (cnt) begin
          w_shift = 1'b1;
          if (r_rem == '0) begin
            w_last      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Word as it will look once the current serial bit is absorbed.
  always_comb begin
    w_idx    = IDX_W'(r_pos);
    w_sr_nxt = r_sr;
    if (MSB_FIRST != 0) begin
      w_sr_nxt = {r_sr[WIDTH-2:0], in};
    end else begin
      w_sr_nxt[w_idx] = in;
    end
  end

  // NOTE: sequential state is written with <= only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem    <= '0;
      r_pos    <= '0;
      r_sr     <= '0;
      r_parout <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= w_last;
      if (w_load) begin
        r_rem <= init;
        r_pos <= '0;
        r_sr  <= '0;
        // A load in IDLE clears err; a load mid-frame flags the abort.
        r_err <= w_abort;
      end else if (w_shift) begin
        r_sr  <= w_sr_nxt;
        r_pos <= r_pos + CNT_W'(1);
        if (r_rem != '0) begin
          r_rem <= r_rem - CNT_W'(1);
        end
      end
      if (w_last) begin
        r_parout <= w_sr_nxt;
      end
    end
  end

  assign parout = r_parout;
  assign valid  = r_valid;
  assign busy   = (r_state == SHIFT);
  assign err    = r_err;

endmodule

// File: doc/nt_serial_collector.md
NT_SERIAL_COLLECTOR -- requirements
Module: nt_serial_collector

Interface
REQ-001 Parameter WIDTH, default 8, parallel output width in bits.
REQ-002 Parameter CNT_W, default 3, width of frame-length preset; 2**CNT_W SHALL be <= WIDTH, otherwise elaboration error.
REQ-003 Parameter MSB_FIRST, default 1, bit order: 1 = first serial bit is most significant, 0 = first serial bit is bit 0.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 in  input  1  serial data bit, sampled when cnt=1 in SHIFT.
REQ-007 cnt  input  1  shift enable; 0 stalls the frame.
REQ-008 ld_cnt  input  1  frame start: loads length from init.
REQ-009 init  input  CNT_W  frame length minus one (init=0 -> 1 bit, all-ones -> 2**CNT_W bits).
REQ-010 parout  output  WIDTH  last completed word, right-aligned, zero-extended.
REQ-011 valid  output  1  one-cycle pulse: parout just updated.
REQ-012 busy  output  1  high while a frame is in progress.
REQ-013 err  output  1  sticky: a frame was aborted by ld_cnt.

Function
REQ-014 FSM SHALL have exactly two states, IDLE and SHIFT; busy SHALL equal (state==SHIFT).
REQ-015 IDLE, ld_cnt=1: load remaining-count = init, position = 0, clear internal shift register, go SHIFT; in SHALL NOT be sampled that cycle, regardless of cnt.
REQ-016 IDLE, ld_cnt=0: hold; cnt ignored.
REQ-017 SHIFT, cnt=1, ld_cnt=0: sample in; MSB_FIRST=1 -> shift register shifts left, in enters bit 0; MSB_FIRST=0 -> in written to bit [position]; position increments, remaining-count decrements.
REQ-018 SHIFT, cnt=0, ld_cnt=0: stall; no state, counter or register change.
REQ-019 Final bit (remaining-count == 0, cnt=1): on that same edge parout SHALL take the assembled word including that bit, valid SHALL be 1 for the following cycle only, state returns to IDLE.
REQ-020 Latency: valid asserted in the cycle after the edge that samples the last bit; frame of n bits with cnt held high completes n+1 edges after ld_cnt is sampled.
REQ-021 SHIFT, ld_cnt=1 (any cnt): partial frame discarded, reload from init as REQ-015, stay in SHIFT, err set to 1; parout and valid unaffected.
REQ-022 err SHALL clear only on reset or on ld_cnt sampled in IDLE.
REQ-023 parout SHALL hold its value between completed frames; bits above the frame length SHALL be 0.
REQ-024 Counter arithmetic SHALL be CNT_W bits; remaining-count never wraps (decrement occurs only when nonzero).
REQ-025 No combinational path from inputs to outputs.

Reset
REQ-026 rst=0 SHALL immediately force state=IDLE, parout=0, valid=0, busy=0, err=0, counters and shift register=0, independent of clk.
REQ-027 Reset asserted mid-frame SHALL discard the frame; no valid pulse on release.
REQ-028 After rst rises, the first ld_cnt SHALL start a frame normally.

Verification
REQ-029 Defaults, init=3, ld_cnt pulse, cnt=1, in=1,1,0,1 -> busy 4 cycles, parout=8'h0D, single valid pulse, err=0.
REQ-030 MSB_FIRST=0, init=3, in=1,1,0,1 -> parout=8'h0B.
REQ-031 init=7, in=1,0,1,0,1,0,1,1 with cnt=0 for 3 cycles after bit 4 -> parout=8'hAB, valid 1 cycle after 8th sampled bit, no change during stall.
REQ-032 init=0, ld_cnt then in=1 -> parout=8'h01 after 1 bit; ld_cnt and cnt high together in IDLE -> no bit sampled that cycle.
REQ-033 init=3, 2 bits in, ld_cnt again with init=1, bits 1,0 -> err=1, parout=8'h02; next ld_cnt in IDLE -> err=0.
REQ-034 rst=0 between clock edges mid-frame -> all outputs 0 immediately, no valid after release, next frame correct.
